// File: rtl/ram_pkg.sv
// Shared RAM operation encoding, default widths and the one-op-per-cycle arbiter.
package ram_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2
    } ram_op_e;

    // On a conflict the op that did not go last wins, so neither side starves.
    function automatic ram_op_e arbitrate(input logic wr_want, input logic rd_want,
                                          input ram_op_e last_op);
        if (wr_want && rd_want) return (last_op == OP_READ) ? OP_WRITE : OP_READ;
        if (wr_want)            return OP_WRITE;
        if (rd_want)            return OP_READ;
        return OP_IDLE;
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl_ram.sv
// Single-port synchronous RAM, read-first, dout valid one cycle after addr.
module synchronous_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        dout <= mem[addr];
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external single-port synchronous RAM, with a
// registered output word prefetched from the RAM head.
module ram_fifo_ctrl
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    ram_op_e               last_op_q, last_op_d, op;

    logic not_full, wr_want, rd_want;

    assign not_full = (ram_cnt_q != DEPTH_C);
    assign wr_want  = in_valid && not_full;
    // Only prefetch when the output slot will be free by the time data returns.
    assign rd_want  = (ram_cnt_q != '0) && !rd_inflight_q && (!out_valid_q || out_ready);
    assign op       = rst ? OP_IDLE : arbitrate(wr_want, rd_want, last_op_q);

    assign in_ready  = !rst && not_full && (!rd_want || last_op_q == OP_READ);
    assign ram_we    = (op == OP_WRITE);
    assign ram_addr  = ram_we ? wr_ptr_q : rd_ptr_q;
    assign ram_din   = in_data;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign level     = ram_cnt_q + (ADDR_WIDTH+1)'(rd_inflight_q)
                                 + (ADDR_WIDTH+1)'(out_valid_q);

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        ram_cnt_d     = ram_cnt_q;
        last_op_d     = last_op_q;
        rd_inflight_d = (op == OP_READ);
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        case (op)
            OP_WRITE: begin
                wr_ptr_d  = wr_ptr_q + 1'b1;
                ram_cnt_d = ram_cnt_q + 1'b1;
                last_op_d = OP_WRITE;
            end
            OP_READ: begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                ram_cnt_d = ram_cnt_q - 1'b1;
                last_op_d = OP_READ;
            end
            default: ;
        endcase
        // A returning read always lands in a slot that is empty or being taken now.
        if (rd_inflight_q) begin
            out_data_d  = ram_dout;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ram_cnt_q     <= '0;
            last_op_q     <= OP_READ;
            rd_inflight_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ram_cnt_q     <= ram_cnt_d;
            last_op_q     <= last_op_d;
            rd_inflight_q <= rd_inflight_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: accepted writes feed a scoreboard queue that a
// negedge monitor drains against the output handshakes; directed checks cover the rest.
module tb_ram_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, ram_we;
    logic [DW-1:0] out_data, ram_din, ram_dout;
    logic [AW:0]   level;
    logic [AW-1:0] ram_addr;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    synchronous_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_ram (
        .clk(clk), .we(ram_we), .addr(ram_addr), .din(ram_din), .dout(ram_dout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: handshakes complete at the next posedge, so sample them mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=%0h required=none", out_data);
                end else begin
                    chk("out_data_order", out_data, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("push_timeout", n < 20, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        #1;
        while (level != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_timeout", n < 100, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int nxt;
        logic acc;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ram_we", ram_we, 0);
        chk("rst_level", level, 0);
        chk("rst_out_valid", out_valid, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_data", out_data, 0);

        // AA then 55 with output blocked: second write loses to the prefetch read
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        #1;
        chk("t1_in_ready_first", in_ready, 1);
        tick();
        in_data = 8'h55;
        #1;
        chk("t1_conflict_in_ready", in_ready, 0);
        chk("t1_conflict_read", ram_we, 0);
        chk("t1_read_addr", ram_addr, 0);
        tick();
        chk("t1_write2_in_ready", in_ready, 1);
        chk("t1_write2_we", ram_we, 1);
        chk("t1_write2_addr", ram_addr, 1);
        chk("t1_out_valid_early", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_data", out_data, 8'hAA);
        chk("t1_level", level, 2);
        drain();

        // Fill: 17 words fit (16 in RAM + 1 in output register), then stall
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push_word(8'(i));
            if (i == 15) begin
                chk("fill16_level", level, 16);
                chk("fill16_in_ready", in_ready, 1);
            end
        end
        chk("full_level", level, 17);
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("full_stall", in_ready, 0);
        end
        chk("full_level_hold", level, 17);
        drain();

        // Streaming: ops alternate W/R; 40 words wrap both pointers twice
        out_ready = 1'b1;
        nxt = 8'h40;
        for (int c = 0; c < 80; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(nxt);
            #1;
            chk("stream_alt_we", ram_we, (c % 2) == 0);
            acc = in_ready;
            tick();
            if (acc) nxt++;
        end
        in_valid = 1'b0;
        chk("stream_count", nxt, 8'h40 + 40);
        drain();

        // Reset the cycle after a READ grant: in-flight word must vanish
        out_ready = 1'b1;
        push_word(8'h11);
        #1;
        chk("t4_read_grant", ram_we, 0);
        tick();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        #1;
        chk("t4_rst_ram_we", ram_we, 0);
        chk("t4_rst_in_ready", in_ready, 0);
        tick();
        chk("t4_out_valid", out_valid, 0);
        chk("t4_level", level, 0);
        chk("t4_out_data", out_data, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_after_out_valid", out_valid, 0);
            chk("t4_after_level", level, 0);
        end

        // Read from empty
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("empty_out_valid", out_valid, 0);
            chk("empty_ram_we", ram_we, 0);
            chk("empty_level", level, 0);
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
